tx_unpacker: RTL and testbench

Transmit-side frame unpacker on the DSP clock domain. Pulls 17-bit words (frame-start flag plus 16-bit sample) from a show-ahead TX FIFO filled by the USB side and de-interleaves them into up to eight per-channel 16-bit sample registers. All channels update together on each `txstrobe`. Detects underrun and frame misalignment. Sits between the TX FIFO read port and the interpolator chains.

---
 rtl/tx_unpacker.sv | 118 +++++++++++
 tb/tb_tx_unpacker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_unpacker.sv
// TX frame unpacker: de-interleaves show-ahead FIFO words into up to eight
// per-channel sample registers, presented together on each txstrobe.
module tx_unpacker (
  input  logic        txclk,
  input  logic        reset,
  input  logic        txstrobe,
  input  logic [3:0]  channels,
  input  logic        mode_8bit,
  input  logic        clear_status,
  input  logic [16:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic [15:0] ch_0,
  output logic [15:0] ch_1,
  output logic [15:0] ch_2,
  output logic [15:0] ch_3,
  output logic [15:0] ch_4,
  output logic [15:0] ch_5,
  output logic [15:0] ch_6,
  output logic [15:0] ch_7,
  output logic        tx_underrun,
  output logic        sync_error
);

  localparam int unsigned NCH = 8;
  localparam int unsigned DW  = 16;
  localparam int unsigned PW  = 4;
  localparam int unsigned SW  = 3;

  logic [PW-1:0] phase, phase_nxt;
  logic [PW-1:0] n_cur, n_lat, n_eff, word_idx;
  logic          mode_lat, mode_eff;
  logic          load, wr_en, sync_set, und_set, present;
  logic [SW-1:0] slot_lo;
  logic [DW-1:0] stg  [NCH];
  logic [DW-1:0] ch_r [NCH];

  // Word count and mode come straight from the inputs while waiting for word 1,
  // from the latched copy for the rest of the frame.
  always_comb begin
    n_cur = mode_8bit ? {1'b0, channels[3:1]} : channels;
    if (n_cur == '0) n_cur = PW'(1);
    n_eff    = (phase == PW'(1)) ? n_cur : n_lat;
    mode_eff = (phase == PW'(1)) ? mode_8bit : mode_lat;
  end

  // Load / framing / phase advance.
  always_comb begin
    present   = txstrobe && (phase == '0);
    und_set   = txstrobe && (phase != '0);
    load      = !reset && (phase != '0) && !fifo_empty;
    phase_nxt = phase;
    wr_en     = 1'b0;
    sync_set  = 1'b0;
    word_idx  = phase;
    if (present) begin
      phase_nxt = PW'(1);
    end else if (load) begin
      if (fifo_q[16] && (phase != PW'(1))) begin
        sync_set = 1'b1;
        word_idx = PW'(1);
      end
      if (!fifo_q[16] && (phase == PW'(1))) begin
        sync_set = 1'b1;
      end else begin
        wr_en     = 1'b1;
        phase_nxt = (word_idx >= n_eff) ? '0 : PW'(word_idx + PW'(1));
      end
    end
    slot_lo = mode_eff ? SW'({PW'(word_idx - PW'(1)), 1'b0})
                       : SW'(word_idx - PW'(1));
  end

  assign fifo_rdreq = load;

  always_ff @(posedge txclk) begin
    if (reset) begin
      phase       <= PW'(1);
      n_lat       <= PW'(1);
      mode_lat    <= 1'b0;
      tx_underrun <= 1'b0;
      sync_error  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        stg[i]  <= '0;
        ch_r[i] <= '0;
      end
    end else begin
      phase <= phase_nxt;
      if (wr_en && (phase == PW'(1))) begin
        n_lat    <= n_cur;
        mode_lat <= mode_8bit;
      end
      if (wr_en) begin
        if (mode_eff) begin
          stg[slot_lo]         <= {fifo_q[7:0], 8'h00};
          stg[slot_lo | SW'(1)] <= {fifo_q[15:8], 8'h00};
        end else begin
          stg[slot_lo] <= fifo_q[15:0];
        end
      end
      if (txstrobe) begin
        for (int i = 0; i < NCH; i++) ch_r[i] <= present ? stg[i] : '0;
      end
      tx_underrun <= und_set  | (tx_underrun & ~clear_status);
      sync_error  <= sync_set | (sync_error  & ~clear_status);
    end
  end

  assign ch_0 = ch_r[0];
  assign ch_1 = ch_r[1];
  assign ch_2 = ch_r[2];
  assign ch_3 = ch_r[3];
  assign ch_4 = ch_r[4];
  assign ch_5 = ch_r[5];
  assign ch_6 = ch_r[6];
  assign ch_7 = ch_r[7];

endmodule

// File: tb/tb_tx_unpacker.sv
// Bench for tx_unpacker: directed frames plus randomized traffic against a
// frame-level model that tracks words collected per frame.
module tb_tx_unpacker;

  logic        txclk = 1'b0;
  logic        reset, txstrobe, mode_8bit, clear_status, fifo_empty, fifo_rdreq;
  logic [3:0]  channels;
  logic [16:0] fifo_q;
  logic [15:0] ch_0, ch_1, ch_2, ch_3, ch_4, ch_5, ch_6, ch_7;
  logic        tx_underrun, sync_error;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pops = 0;

  logic [16:0] fq[$];

  // model state: words collected so far in the frame being assembled
  int          m_got, m_n;
  bit          m_done, m_8, m_load, m_und, m_sync;
  logic [15:0] m_stg [8];
  logic [15:0] m_ch  [8];

  tx_unpacker dut (
    .txclk(txclk), .reset(reset), .txstrobe(txstrobe), .channels(channels),
    .mode_8bit(mode_8bit), .clear_status(clear_status), .fifo_q(fifo_q),
    .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .ch_0(ch_0), .ch_1(ch_1), .ch_2(ch_2), .ch_3(ch_3),
    .ch_4(ch_4), .ch_5(ch_5), .ch_6(ch_6), .ch_7(ch_7),
    .tx_underrun(tx_underrun), .sync_error(sync_error)
  );

  always #5 txclk = ~txclk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int n_of(input logic [3:0] c, input logic m);
    int n = m ? int'(c) / 2 : int'(c);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [127:0] dut_chs();
    return {ch_7, ch_6, ch_5, ch_4, ch_3, ch_2, ch_1, ch_0};
  endfunction

  function automatic logic [127:0] model_chs();
    logic [127:0] v = '0;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = m_ch[i];
    return v;
  endfunction

  task automatic model_store(input int j, input logic [15:0] d);
    if (m_8) begin
      m_stg[2*j]   = {d[7:0], 8'h00};
      m_stg[2*j+1] = {d[15:8], 8'h00};
    end else begin
      m_stg[j] = d;
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit und_set, sync_set;
    und_set  = 1'b0;
    sync_set = 1'b0;
    if (reset) begin
      m_got = 0; m_done = 0; m_und = 0; m_sync = 0;
      for (int i = 0; i < 8; i++) begin m_stg[i] = '0; m_ch[i] = '0; end
      return;
    end
    und_set = txstrobe && !m_done;
    if (txstrobe && m_done) begin
      m_ch   = m_stg;
      m_done = 0;
      m_got  = 0;
    end else begin
      if (txstrobe) for (int i = 0; i < 8; i++) m_ch[i] = '0;
      if (m_load) begin
        if (fifo_q[16]) begin
          if (m_got == 0) begin
            m_n = n_of(channels, mode_8bit);
            m_8 = mode_8bit;
          end else begin
            sync_set = 1'b1;
          end
          model_store(0, fifo_q[15:0]);
          m_got = 1;
        end else if (m_got == 0) begin
          sync_set = 1'b1;
        end else begin
          model_store(m_got, fifo_q[15:0]);
          m_got++;
        end
        if (m_got > 0 && m_got >= m_n) m_done = 1;
      end
    end
    m_und  = und_set  || (m_und  && !clear_status);
    m_sync = sync_set || (m_sync && !clear_status);
  endtask

  task automatic step();
    bit popped;
    fifo_q     = (fq.size() > 0) ? fq[0] : 17'h0;
    fifo_empty = (fq.size() == 0);
    #1;
    m_load = !reset && !m_done && !fifo_empty;
    chk("fifo_rdreq", 128'(fifo_rdreq), 128'(m_load));
    popped = fifo_rdreq;
    if (popped) pops++;
    model_step();
    @(posedge txclk);
    #1;
    if (popped && fq.size() > 0) void'(fq.pop_front());
    chk("channels", dut_chs(), model_chs());
    chk("tx_underrun", 128'(tx_underrun), 128'(m_und));
    chk("sync_error", 128'(sync_error), 128'(m_sync));
    @(negedge txclk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe_step();
    txstrobe = 1'b1;
    step();
    txstrobe = 1'b0;
  endtask

  task automatic push(input logic f, input logic [15:0] d);
    fq.push_back({f, d});
  endtask

  initial begin
    int gpos, gn;
    logic fl;
    reset = 1'b1; txstrobe = 1'b0; channels = 4'd2; mode_8bit = 1'b0;
    clear_status = 1'b0; fifo_q = '0; fifo_empty = 1'b1;
    m_got = 0; m_n = 1; m_done = 0; m_8 = 0; m_load = 0; m_und = 0; m_sync = 0;
    for (int i = 0; i < 8; i++) begin m_stg[i] = '0; m_ch[i] = '0; end
    @(negedge txclk);
    steps(3);
    chk("reset_ch", dut_chs(), 128'h0);
    chk("reset_flags", 128'({tx_underrun, sync_error}), 128'h0);

    // 2 channels, 16-bit
    push(1'b1, 16'h1111); push(1'b0, 16'h2222);
    reset = 1'b0; pops = 0;
    steps(4);
    strobe_step();
    chk("t1_pops", 128'(pops), 128'd2);
    chk("t1_ch", dut_chs(), {96'h0, 16'h2222, 16'h1111});
    chk("t1_flags", 128'({tx_underrun, sync_error}), 128'h0);

    // 8 channels, 8-bit
    channels = 4'd8; mode_8bit = 1'b1; pops = 0;
    push(1'b1, 16'hB2A1); push(1'b0, 16'hD4C3); push(1'b0, 16'hF6E5); push(1'b0, 16'h1807);
    steps(6);
    strobe_step();
    chk("t2_pops", 128'(pops), 128'd4);
    chk("t2_ch", dut_chs(), {16'h1800, 16'h0700, 16'hF600, 16'hE500,
                             16'hD400, 16'hC300, 16'hB200, 16'hA100});

    // underrun on empty FIFO, then refill
    channels = 4'd4; mode_8bit = 1'b0;
    steps(9);
    strobe_step();
    chk("t3_ch_zero", dut_chs(), 128'h0);
    chk("t3_underrun", 128'(tx_underrun), 128'd1);
    push(1'b1, 16'h0A01); push(1'b0, 16'h0A02); push(1'b0, 16'h0A03); push(1'b0, 16'h0A04);
    steps(6);
    strobe_step();
    chk("t3_ch_data", dut_chs()[63:0], {16'h0A04, 16'h0A03, 16'h0A02, 16'h0A01});
    chk("t3_underrun_sticky", 128'(tx_underrun), 128'd1);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("t3_cleared", 128'(tx_underrun), 128'd0);

    // stray word before frame start
    push(1'b0, 16'hDEAD);
    push(1'b1, 16'h0001); push(1'b0, 16'h0002); push(1'b0, 16'h0003); push(1'b0, 16'h0004);
    steps(7);
    strobe_step();
    chk("t4_sync", 128'(sync_error), 128'd1);
    chk("t4_ch", dut_chs()[63:0], {16'h0004, 16'h0003, 16'h0002, 16'h0001});
    clear_status = 1'b1; step(); clear_status = 1'b0;

    // truncated frame, resync on a new start flag
    push(1'b1, 16'hAAAA); push(1'b0, 16'hBBBB);
    push(1'b1, 16'h0001); push(1'b0, 16'h0002); push(1'b0, 16'h0003); push(1'b0, 16'h0004);
    steps(8);
    strobe_step();
    chk("t5_sync", 128'(sync_error), 128'd1);
    chk("t5_ch", dut_chs()[63:0], {16'h0004, 16'h0003, 16'h0002, 16'h0001});
    clear_status = 1'b1; step(); clear_status = 1'b0;

    // final word lands on the strobe cycle
    channels = 4'd2;
    push(1'b1, 16'h5555);
    step();
    push(1'b0, 16'h6666);
    strobe_step();
    chk("t6_underrun", 128'(tx_underrun), 128'd1);
    chk("t6_ch_zero", dut_chs(), 128'h0);
    steps(2);
    strobe_step();
    chk("t6_ch", dut_chs()[31:0], {16'h6666, 16'h5555});

    // randomized traffic, with a reset (possibly mid-frame) per epoch
    for (int ep = 0; ep < 6; ep++) begin
      reset = 1'b1; step(); reset = 1'b0;
      channels  = 4'(2 * $urandom_range(1, 4));
      mode_8bit = 1'($urandom % 2);
      gn   = n_of(channels, mode_8bit);
      gpos = 0;
      for (int c = 0; c < 120; c++) begin
        if (fq.size() < 24 && ($urandom % 3) != 0) begin
          fl = (gpos == 0);
          if (($urandom % 20) == 0) fl = ~fl;
          push(fl, 16'($urandom));
          gpos = (gpos + 1) % gn;
        end
        txstrobe     = (($urandom % 5) == 0);
        clear_status = (($urandom % 16) == 0);
        step();
        txstrobe     = 1'b0;
        clear_status = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
